// File: rtl/column_sweep_scheduler.sv
// rtl/column_sweep_scheduler.sv - handshaked column-pair sweep per rotational slice with overrun counting
// Optional: RESTART_ON_OVERRUN_EN restarts the sweep at the new theta when theta moves mid-sweep.
module column_sweep_scheduler #(
  parameter int ROTATIONAL_RES = 1024,
  parameter int SCAN_RATE      = 32,
  parameter int FETCH_LATENCY  = 2
) (
  input  logic                              clk_in,
  input  logic                              rst_n_in,
  input  logic                              enable_in,
  input  logic [$clog2(ROTATIONAL_RES)-1:0] dtheta_in,
  input  logic                              hub75_ready_in,
  output logic [$clog2(SCAN_RATE)-1:0]      col_index1_out,
  output logic [$clog2(SCAN_RATE):0]        col_index2_out,
  output logic                              col_valid_out,
  output logic [$clog2(ROTATIONAL_RES)-1:0] theta_latched_out,
  output logic                              busy_out,
  output logic                              frame_done_out,
  output logic [15:0]                       overrun_count_out
);

  localparam int TW = $clog2(ROTATIONAL_RES);
  localparam int CW = $clog2(SCAN_RATE);
  localparam logic [CW-1:0] LP_LAST  = CW'(SCAN_RATE - 1);
  localparam logic [CW:0]   LP_SCAN  = (CW + 1)'(SCAN_RATE);
  localparam logic [3:0]    LP_FETCH = 4'(FETCH_LATENCY);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_PRESENT, S_DONE} state_t;

  state_t        r_state, w_state_next;
  logic [CW-1:0] r_idx, w_idx_next;
  logic [CW:0]   r_idx2;
  logic [TW-1:0] r_theta, w_theta_next;
  logic [TW-1:0] r_dtheta_prev;
  logic          r_first, w_first_next;
  logic          r_valid, w_valid_next;
  logic          r_done, w_done_next;
  logic [3:0]    r_wait, w_wait_next;
  logic [15:0]   r_overrun;
  logic          w_idx_load;
  logic          w_overrun;

  assign w_overrun = (r_state != S_IDLE) && (dtheta_in != r_dtheta_prev);

  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    w_theta_next = r_theta;
    w_first_next = r_first;
    w_valid_next = r_valid;
    w_done_next  = 1'b0;
    w_wait_next  = r_wait;
    w_idx_load   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (enable_in && (r_first || (dtheta_in != r_theta))) begin
          w_theta_next = dtheta_in;
          w_idx_next   = '0;
          w_idx_load   = 1'b1;
          w_first_next = 1'b0;
          w_state_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_wait_next = LP_FETCH;
        if (FETCH_LATENCY > 0) begin
          w_state_next = S_WAIT;
        end else begin
          w_state_next = S_PRESENT;
          w_valid_next = 1'b1;
        end
      end
      S_WAIT: begin
        // Leaving on count 1 makes WAIT last exactly FETCH_LATENCY cycles.
        if (r_wait <= 4'd1) begin
          w_state_next = S_PRESENT;
          w_valid_next = 1'b1;
        end else begin
          w_wait_next = r_wait - 4'd1;
        end
      end
      S_PRESENT: begin
        if (hub75_ready_in && r_valid) begin
          w_valid_next = 1'b0;
          if (r_idx == LP_LAST) begin
            w_state_next = S_DONE;
            w_done_next  = 1'b1;
          end else begin
            w_idx_next   = r_idx + 1'b1;
            w_idx_load   = 1'b1;
            w_state_next = S_ISSUE;
          end
        end
      end
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
`ifdef RESTART_ON_OVERRUN_EN
    if (w_overrun && (r_state != S_DONE)) begin
      w_theta_next = dtheta_in;
      w_idx_next   = '0;
      w_idx_load   = 1'b1;
      w_valid_next = 1'b0;
      w_done_next  = 1'b0;
      w_state_next = S_ISSUE;
    end
`endif
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state       <= S_IDLE;
      r_idx         <= '0;
      r_idx2        <= '0;
      r_theta       <= '0;
      r_dtheta_prev <= '0;
      r_first       <= 1'b1;
      r_valid       <= 1'b0;
      r_done        <= 1'b0;
      r_wait        <= '0;
      r_overrun     <= '0;
    end else begin
      r_state       <= w_state_next;
      r_idx         <= w_idx_next;
      r_theta       <= w_theta_next;
      r_dtheta_prev <= dtheta_in;
      r_first       <= w_first_next;
      r_valid       <= w_valid_next;
      r_done        <= w_done_next;
      r_wait        <= w_wait_next;
      if (w_idx_load) begin
        r_idx2 <= {1'b0, w_idx_next} + LP_SCAN;
      end
      if (w_overrun && (r_overrun != 16'hFFFF)) begin
        r_overrun <= r_overrun + 16'd1;
      end
    end
  end

  assign col_index1_out    = r_idx;
  assign col_index2_out    = r_idx2;
  assign col_valid_out     = r_valid;
  assign theta_latched_out = r_theta;
  assign busy_out          = (r_state != S_IDLE);
  assign frame_done_out    = r_done;
  assign overrun_count_out = r_overrun;

endmodule

// File: tb/tb_column_sweep_scheduler.sv
// tb/tb_column_sweep_scheduler.sv - directed vector bench for column_sweep_scheduler at default parameters
module tb_column_sweep_scheduler;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic        enable_in;
  logic [9:0]  dtheta_in;
  logic        hub75_ready_in;
  logic [4:0]  col_index1_out;
  logic [5:0]  col_index2_out;
  logic        col_valid_out;
  logic [9:0]  theta_latched_out;
  logic        busy_out;
  logic        frame_done_out;
  logic [15:0] overrun_count_out;

  int checks = 0;
  int errors = 0;

  column_sweep_scheduler dut (
    .clk_in            (clk_in),
    .rst_n_in          (rst_n_in),
    .enable_in         (enable_in),
    .dtheta_in         (dtheta_in),
    .hub75_ready_in    (hub75_ready_in),
    .col_index1_out    (col_index1_out),
    .col_index2_out    (col_index2_out),
    .col_valid_out     (col_valid_out),
    .theta_latched_out (theta_latched_out),
    .busy_out          (busy_out),
    .frame_done_out    (frame_done_out),
    .overrun_count_out (overrun_count_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    int en; int th; int rdy; int n;
    int busy; int valid; int idx1; int idx2; int theta; int done; int ov;
  } vec_t;

  vec_t tbl[15];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic chk_all(input string tag, input int busy, input int valid, input int idx1,
                         input int idx2, input int theta, input int done, input int ov);
    chk({tag, ".busy"},  int'(busy_out), busy);
    chk({tag, ".valid"}, int'(col_valid_out), valid);
    chk({tag, ".idx1"},  int'(col_index1_out), idx1);
    chk({tag, ".idx2"},  int'(col_index2_out), idx2);
    chk({tag, ".theta"}, int'(theta_latched_out), theta);
    chk({tag, ".done"},  int'(frame_done_out), done);
    chk({tag, ".ov"},    int'(overrun_count_out), ov);
  endtask

  initial begin
    // Vectors continue from the idle state after the first sweep (theta 5, index 31).
    //           en  th rdy   n  busy val idx1 idx2 th done ov
    tbl[0]  = '{1,   5,  1,   5,  0,   0,  31,  63, 5,  0,  0};
    tbl[1]  = '{1,   6,  1,   1,  1,   0,   0,  32, 6,  0,  0};
    tbl[2]  = '{1,   6,  1,  30,  1,   0,   7,  39, 6,  0,  0};
    tbl[3]  = '{1,   6,  0,   1,  1,   1,   7,  39, 6,  0,  0};
    tbl[4]  = '{1,   6,  0,  10,  1,   1,   7,  39, 6,  0,  0};
    tbl[5]  = '{1,   6,  1,   1,  1,   0,   8,  40, 6,  0,  0};
    tbl[6]  = '{1,   6,  0,   3,  1,   1,   8,  40, 6,  0,  0};
    tbl[7]  = '{1,   7,  1,   1,  1,   0,   9,  41, 6,  0,  1};
    tbl[8]  = '{1,   8,  1,   1,  1,   0,   9,  41, 6,  0,  2};
    tbl[9]  = '{1,   8,  1,  91,  1,   0,  31,  63, 6,  1,  2};
    tbl[10] = '{1,   8,  1,   1,  0,   0,  31,  63, 6,  0,  2};
    tbl[11] = '{1,   8,  1,   1,  1,   0,   0,  32, 8,  0,  2};
    tbl[12] = '{0,   8,  1, 128,  1,   0,  31,  63, 8,  1,  2};
    tbl[13] = '{0,   8,  1,   1,  0,   0,  31,  63, 8,  0,  2};
    tbl[14] = '{0,   9,  1,   5,  0,   0,  31,  63, 8,  0,  2};

    rst_n_in = 1'b0;
    enable_in = 1'b1;
    dtheta_in = 10'd5;
    hub75_ready_in = 1'b1;
    #12;
    chk_all("reset", 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk_in);
    rst_n_in = 1'b1;

    // First sweep: column c issued at edge 4c, valid at edge 4c+3, done after edge 128.
    for (int k = 0; k < 130; k++) begin
      int c;
      step(1);
      c = (k < 128) ? k / 4 : 31;
      chk($sformatf("sweep1.idx1[%0d]", k), int'(col_index1_out), c);
      chk($sformatf("sweep1.idx2[%0d]", k), int'(col_index2_out), c + 32);
      chk($sformatf("sweep1.valid[%0d]", k), int'(col_valid_out), (k < 128 && k % 4 == 3) ? 1 : 0);
      chk($sformatf("sweep1.done[%0d]", k), int'(frame_done_out), (k == 128) ? 1 : 0);
      chk($sformatf("sweep1.busy[%0d]", k), int'(busy_out), (k <= 128) ? 1 : 0);
    end
    chk("sweep1.theta", int'(theta_latched_out), 5);

    for (int v = 0; v < 15; v++) begin
      enable_in = tbl[v].en[0];
      dtheta_in = 10'(tbl[v].th);
      hub75_ready_in = tbl[v].rdy[0];
      step(tbl[v].n);
      chk_all($sformatf("vec%0d", v), tbl[v].busy, tbl[v].valid, tbl[v].idx1, tbl[v].idx2,
              tbl[v].theta, tbl[v].done, tbl[v].ov);
    end

    // Asynchronous reset in the middle of PRESENT, sampled before the next edge.
    enable_in = 1'b1;
    hub75_ready_in = 1'b0;
    step(4);
    chk("mid.valid_before_reset", int'(col_valid_out), 1);
    rst_n_in = 1'b0;
    #1;
    chk_all("async_reset", 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk_in);
    dtheta_in = 10'd0;
    hub75_ready_in = 1'b1;
    rst_n_in = 1'b1;
    step(1);
    chk_all("first_flag", 1, 0, 0, 32, 0, 0, 0);

    // Saturation: ready held low keeps the sweep busy while theta toggles every cycle.
    hub75_ready_in = 1'b0;
    for (int i = 0; i < 70000; i++) begin
      dtheta_in = (i % 2 == 0) ? 10'd1 : 10'd2;
      step(1);
      if (i == 999)   chk("ov.1000", int'(overrun_count_out), 1000);
      if (i == 65534) chk("ov.65535", int'(overrun_count_out), 65535);
    end
    chk("ov.saturated", int'(overrun_count_out), 65535);
    chk("ov.busy", int'(busy_out), 1);
    chk("ov.valid", int'(col_valid_out), 1);
    chk("ov.theta", int'(theta_latched_out), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
